button_pio: RTL and testbench

- Avalon-MM slave input peripheral for push-buttons and switches.
- Complements the write-only LED output port: this block is the read-side end of the same slave bus.
- Synchronises and debounces up to WIDTH raw inputs, latches press events in an edge-capture register, and raises a maskable interrupt.
- The CPU reads state and events through registered reads.

---
 rtl/button_pio_if.sv | 13 +
 rtl/button_pio.sv | 128 ++++++++++++
 tb/tb_button_pio.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/button_pio_if.sv
// Avalon-MM slave bus for the button/switch input peripheral.
interface button_pio_if;
  logic [3:0] slave_address;
  logic       slave_read;
  logic       slave_write;
  logic [7:0] slave_writedata;
  logic [7:0] slave_readdata;

  modport master (output slave_address, slave_read, slave_write, slave_writedata,
                  input  slave_readdata);
  modport slave  (input  slave_address, slave_read, slave_write, slave_writedata,
                  output slave_readdata);
endinterface

// File: rtl/button_pio.sv
// Debounced push-button/switch input port with edge capture and maskable irq.
// Define BUTTON_PIO_DEBOUNCE_EN to build the per-line debounce counters.

module button_pio_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned CNT_W           = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic raw,
  output logic state,
  output logic press
);
  logic [1:0] sync_q;
  logic       state_q;
  logic       accept;

  if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_bad_cfg
    $error("button_pio: need DEBOUNCE_CYCLES >= 2 and 2**CNT_W > DEBOUNCE_CYCLES");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], din};
  end

  assign raw = sync_q[1];

`ifdef BUTTON_PIO_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q;

  // Any cycle where raw agrees with state restarts the stability count.
  assign accept = (raw != state_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else if (raw == state_q) begin
      cnt_q   <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      state_q <= raw;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign accept = (raw != state_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= 1'b0;
    else          state_q <= raw;
  end
`endif

  assign state = state_q;
  assign press = accept & raw;
endmodule

module button_pio #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  button_pio_if.slave      bus,
  output logic             irq,
  input  logic [WIDTH-1:0] user_datain_0
);
  logic [WIDTH-1:0] din, raw, state, press;
  logic [WIDTH-1:0] mask_q, edge_q, edge_clr, rd_mux;
  logic             addr_ok;

  assign din = ACTIVE_LOW ? ~user_datain_0 : user_datain_0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    button_pio_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (din[i]),
      .raw    (raw[i]),
      .state  (state[i]),
      .press  (press[i])
    );
  end

  assign addr_ok  = (bus.slave_address[3:2] == 2'b00);
  assign edge_clr = (bus.slave_write && addr_ok && bus.slave_address[1:0] == 2'd2)
                    ? bus.slave_writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      if (bus.slave_write && addr_ok && bus.slave_address[1:0] == 2'd1)
        mask_q <= bus.slave_writedata[WIDTH-1:0];
      // A new press beats a simultaneous W1C of the same bit.
      edge_q <= (edge_q & ~edge_clr) | press;
    end
  end

  assign irq = |(edge_q & mask_q);

  always_comb begin
    rd_mux = '0;
    if (addr_ok) begin
      case (bus.slave_address[1:0])
        2'd0:    rd_mux = state;
        2'd1:    rd_mux = mask_q;
        2'd2:    rd_mux = edge_q;
        default: rd_mux = raw;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            bus.slave_readdata <= '0;
    else if (bus.slave_read) bus.slave_readdata <= 8'(rd_mux);
  end
endmodule

// File: tb/tb_button_pio.sv
// Scoreboard bench for button_pio: expected read data is queued as each read
// is issued and compared when the registered read data appears.
module tb_button_pio;
  localparam int WIDTH = 8;
  localparam int DB    = 4;
  localparam int CW    = 4;
`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 3;
`endif

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] din     = 8'hFF;
  logic             irq;
  logic             rd_seen = 1'b0;

  always #5 clk = ~clk;

  button_pio_if bus();

  button_pio #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .CNT_W(CW), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .irq          (irq),
    .user_datain_0(din)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  string      tag_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
  endtask

  always @(posedge clk) rd_seen <= bus.slave_read;

  always @(negedge clk) begin
    string      t;
    logic [7:0] e;
    if (rd_seen) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        chk(t, {24'd0, bus.slave_readdata}, {24'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string t);
    bus.slave_address = a; bus.slave_read = 1'b1;
    tag_q.push_back(t); exp_q.push_back(e);
    step();
    bus.slave_read = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.slave_address = a; bus.slave_writedata = d; bus.slave_write = 1'b1;
    step();
    bus.slave_write = 1'b0;
  endtask

  task automatic rdwr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] e, input string t);
    bus.slave_address = a; bus.slave_writedata = d;
    bus.slave_write = 1'b1; bus.slave_read = 1'b1;
    tag_q.push_back(t); exp_q.push_back(e);
    step();
    bus.slave_write = 1'b0; bus.slave_read = 1'b0;
  endtask

  initial begin
    bus.slave_address = '0; bus.slave_read = 1'b0;
    bus.slave_write = 1'b0; bus.slave_writedata = '0;

    // reset with inputs toggling
    for (int i = 0; i < 4; i++) begin
      step();
      din = 8'($urandom);
    end
    din = 8'hFF;
    step();
    reset_n = 1'b1;
    idle(3);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) rd(4'(a), 8'h00, "rst_read");
    rd(4'd5, 8'h00, "rst_read_hi");

    // clean press of bit0, exact latency
    din = 8'hFE;
    rd(4'd3, 8'h00, "raw_e1");
    rd(4'd3, 8'h00, "raw_e2");
    rd(4'd3, 8'h01, "raw_e3");
    for (int j = 4; j <= LAT; j++) rd(4'd0, 8'h00, "state_pre");
    rd(4'd0, 8'h01, "state_on");
    rd(4'd2, 8'h01, "edge_on");
    chk("irq_masked", {31'd0, irq}, 32'd0);

`ifdef BUTTON_PIO_DEBOUNCE_EN
    // bounce on bit1 faster than the debounce window
    for (int k = 0; k < 10; k++) begin
      din[1] = 1'b0;
      rd(4'd0, 8'h01, "bounce_state"); rd(4'd0, 8'h01, "bounce_state");
      din[1] = 1'b1;
      rd(4'd0, 8'h01, "bounce_state"); rd(4'd0, 8'h01, "bounce_state");
    end
    idle(LAT + 2);
    rd(4'd0, 8'h01, "bounce_state_end");
    rd(4'd2, 8'h01, "bounce_edge");
`endif

    // interrupt flow
    wr(4'd2, 8'h01);
    rd(4'd2, 8'h00, "edge_w1c");
    wr(4'd1, 8'h01);
    rd(4'd1, 8'h01, "mask_rb");
    chk("irq_idle", {31'd0, irq}, 32'd0);
    din = 8'hFF;
    idle(LAT + 2);
    rd(4'd0, 8'h00, "state_rel");
    rd(4'd2, 8'h00, "edge_rel");
    din = 8'hFE;
    for (int j = 1; j <= LAT; j++) begin
      step();
      chk("irq_rise", {31'd0, irq}, (j == LAT) ? 32'd1 : 32'd0);
    end
    rd(4'd2, 8'h01, "edge_irq");
    chk("irq_after_rd", {31'd0, irq}, 32'd1);
    rd(4'd2, 8'h01, "edge_irq2");
    chk("irq_after_rd2", {31'd0, irq}, 32'd1);
    wr(4'd2, 8'h01);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd(4'd2, 8'h00, "edge_clr");

    // W1C lands on the edge that bit2 is accepted: set wins
    din = 8'hFA;
    idle(LAT - 1);
    wr(4'd2, 8'h04);
    rd(4'd2, 8'h04, "edge_coll");
    rd(4'd0, 8'h05, "state_coll");
    chk("irq_coll", {31'd0, irq}, 32'd0);

    // read-during-write and ignored writes
    rdwr(4'd1, 8'h55, 8'h01, "rdwr_pre");
    rd(4'd1, 8'h55, "mask_new");
    wr(4'd3, 8'hFF); wr(4'd0, 8'hFF); wr(4'd7, 8'hFF);
    rd(4'd1, 8'h55, "mask_keep");
    rd(4'd0, 8'h05, "state_keep");
    rd(4'd7, 8'h00, "addr7");
    chk("irq_mask_on", {31'd0, irq}, 32'd1);

    // reset mid-debounce with bits 0..3 held pressed
    din = 8'hF0;
    idle(3);
    reset_n = 1'b0;
    #1;
    chk("irq_async_rst", {31'd0, irq}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    rd(4'd3, 8'h00, "rr_raw_e1");
    rd(4'd3, 8'h00, "rr_raw_e2");
    rd(4'd3, 8'h0F, "rr_raw_e3");
    for (int j = 4; j <= LAT; j++) rd(4'd0, 8'h00, "rr_state_pre");
    rd(4'd0, 8'h0F, "rr_state_on");
    rd(4'd2, 8'h0F, "rr_edge_on");
    rd(4'd1, 8'h00, "rr_mask");
    chk("rr_irq", {31'd0, irq}, 32'd0);

    idle(2);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
